// File: rtl/virtio_csr_initiator.sv
`timescale 1ns/1ps
// Device-side master of the virtio legacy CSR port. It fetches a queue's PFN, size and MSI-X vector
// through the shared queue-select window on notify, and it posts ISR status writes.
module virtio_csr_initiator #(
    parameter int NUM_QUEUES = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             notify_valid,
    input  logic [15:0]      notify_qidx,
    output logic             notify_ready,
    input  logic             isr_req,
    input  logic [7:0]       isr_val,
    output logic             isr_ack,
    output logic             m_en,
    input  logic             m_gnt,
    output logic [3:0]       m_we,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_din,
    input  logic [31:0]      m_dout,
    output logic             qinfo_valid,
    input  logic             qinfo_ready,
    output logic [15:0]      qinfo_qidx,
    output logic [31:0]      qinfo_pfn,
    output logic [15:0]      qinfo_size,
    output logic [15:0]      qinfo_msix,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       dbg_state
);
    // Handshakes: a notify or qinfo transfer happens in a cycle where valid and ready are both high.
    // Valid never depends on ready. Once valid is raised, it is held with a stable payload until the transfer.
    typedef enum logic [3:0] {
        S_IDLE, S_RD_STAT, S_CHK_STAT, S_SAVE_SEL, S_SET_SEL, S_RD_ADDR,
        S_RD_SIZE, S_RD_MSIX, S_RESTORE, S_OUT, S_ISR_WR
    } state_t;

    localparam logic [31:0] A_PFN  = 32'h0000_0008;
    localparam logic [31:0] A_SEL  = 32'h0000_000c;
    localparam logic [31:0] A_STAT = 32'h0000_0010;
    localparam logic [31:0] A_MSIX = 32'h0000_0014;
    localparam logic [15:0] NQ     = 16'(NUM_QUEUES);

    state_t      state_q, state_d;
    state_t      last_rd_q;
    logic [15:0] qidx_q, host_sel_q, size_q, msix_q;
    logic [31:0] pfn_q;
    logic [7:0]  isr_q;
    logic        notify_acc, isr_acc, qidx_err, drop;

    assign dbg_state   = state_q;
    assign qinfo_valid = (state_q == S_OUT);
    assign qinfo_qidx  = qidx_q;
    assign qinfo_pfn   = pfn_q;
    assign qinfo_size  = size_q;
    assign qinfo_msix  = msix_q;

    always_comb begin
        state_d      = state_q;
        m_en         = 1'b0;
        m_we         = 4'b0000;
        m_addr       = 32'h0;
        m_din        = 32'h0;
        isr_ack      = 1'b0;
        notify_ready = 1'b0;
        notify_acc   = 1'b0;
        isr_acc      = 1'b0;
        qidx_err     = 1'b0;
        drop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Notify wins over a simultaneous ISR request.
                notify_ready = !rst && (notify_valid || !isr_req);
                if (notify_valid && notify_ready) begin
                    notify_acc = 1'b1;
                    if (notify_qidx >= NQ) qidx_err = 1'b1;
                    else                   state_d  = S_RD_STAT;
                end else if (isr_req) begin
                    isr_acc = 1'b1;
                    state_d = S_ISR_WR;
                end
            end
            S_RD_STAT: begin
                m_en   = 1'b1;
                m_addr = A_STAT;
                if (m_gnt) state_d = S_CHK_STAT;
            end
            S_CHK_STAT: begin
                // DRIVER_OK arrives here. If it is clear, leave before touching the select.
                if (m_dout[18]) state_d = S_SAVE_SEL;
                else begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SAVE_SEL: begin
                m_en   = 1'b1;
                m_addr = A_SEL;
                if (m_gnt) state_d = S_SET_SEL;
            end
            S_SET_SEL: begin
                m_en   = 1'b1;
                m_we   = 4'b1100;
                m_addr = A_SEL;
                m_din  = {qidx_q, 16'h0};
                if (m_gnt) state_d = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                m_en   = 1'b1;
                m_addr = A_PFN;
                if (m_gnt) state_d = S_RD_SIZE;
            end
            S_RD_SIZE: begin
                m_en   = 1'b1;
                m_addr = A_SEL;
                if (m_gnt) state_d = S_RD_MSIX;
            end
            S_RD_MSIX: begin
                m_en   = 1'b1;
                m_addr = A_MSIX;
                if (m_gnt) state_d = S_RESTORE;
            end
            S_RESTORE: begin
                m_en   = 1'b1;
                m_we   = 4'b1100;
                m_addr = A_SEL;
                m_din  = {host_sel_q, 16'h0};
                if (m_gnt) state_d = S_OUT;
            end
            S_OUT: begin
                if (qinfo_ready) state_d = S_IDLE;
            end
            S_ISR_WR: begin
                m_en    = 1'b1;
                m_we    = 4'b1000;
                m_addr  = A_STAT;
                m_din   = {isr_q, 24'h0};
                isr_ack = m_gnt;
                if (m_gnt) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_rd_q  <= S_IDLE;
            qidx_q     <= '0;
            host_sel_q <= '0;
            pfn_q      <= '0;
            size_q     <= '0;
            msix_q     <= '0;
            isr_q      <= '0;
            drop_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            state_q   <= state_d;
            // Remember which read was granted so that its data is captured one cycle later.
            last_rd_q <= (m_en && m_gnt && m_we == 4'b0000) ? state_q : S_IDLE;
            if (notify_acc) qidx_q <= notify_qidx;
            if (isr_acc)    isr_q  <= isr_val;
            if (qidx_err && err_cnt != '1)  err_cnt  <= err_cnt + CNT_W'(1);
            if (drop && drop_cnt != '1)     drop_cnt <= drop_cnt + CNT_W'(1);
            case (last_rd_q)
                S_SAVE_SEL: host_sel_q <= m_dout[31:16];
                S_RD_ADDR:  pfn_q      <= m_dout;
                S_RD_SIZE:  size_q     <= m_dout[15:0];
                S_RD_MSIX:  msix_q     <= m_dout[31:16];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_virtio_csr_initiator.sv
`timescale 1ns/1ps
// Bench for virtio_csr_initiator. A CSR memory model answers the port, and scoreboards hold the
// expected bus accesses and queue-info records.
module tb_virtio_csr_initiator;
  localparam int NUM_QUEUES = 3;
  localparam int CNT_W = 16;
  localparam logic [15:0] HOST_SEL = 16'd2;

  logic clk, rst;
  logic notify_valid, notify_ready, isr_req, isr_ack;
  logic [15:0] notify_qidx;
  logic [7:0] isr_val;
  logic m_en, m_gnt;
  logic [3:0] m_we;
  logic [31:0] m_addr, m_din, m_dout;
  logic qinfo_valid, qinfo_ready;
  logic [15:0] qinfo_qidx, qinfo_size, qinfo_msix;
  logic [31:0] qinfo_pfn;
  logic [CNT_W-1:0] drop_cnt, err_cnt;
  logic [3:0] dbg_state;

  virtio_csr_initiator #(.NUM_QUEUES(NUM_QUEUES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .notify_valid(notify_valid), .notify_qidx(notify_qidx), .notify_ready(notify_ready),
    .isr_req(isr_req), .isr_val(isr_val), .isr_ack(isr_ack),
    .m_en(m_en), .m_gnt(m_gnt), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout),
    .qinfo_valid(qinfo_valid), .qinfo_ready(qinfo_ready), .qinfo_qidx(qinfo_qidx),
    .qinfo_pfn(qinfo_pfn), .qinfo_size(qinfo_size), .qinfo_msix(qinfo_msix),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [67:0] exp_q[$];
  logic [79:0] qexp_q[$];
  int ack_cnt = 0;
  logic acc_seen = 1'b0;
  logic rand_gnt = 1'b0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // CSR model: 1-cycle read latency, selected-queue window at 0x08/0x0c/0x14
  logic [31:0] csr_stat;
  logic [15:0] csr_sel;
  logic [7:0] isr_byte;
  logic [31:0] q_pfn[4];
  logic [15:0] q_size[4];
  logic [15:0] q_msix[4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_sel <= HOST_SEL;
      m_dout <= '0;
      isr_byte <= '0;
    end else if (m_en && m_gnt) begin
      if (m_we == 4'b0000) begin
        case (m_addr)
          32'h08: m_dout <= q_pfn[csr_sel[1:0]];
          32'h0c: m_dout <= {csr_sel, q_size[csr_sel[1:0]]};
          32'h10: m_dout <= csr_stat;
          32'h14: m_dout <= {q_msix[csr_sel[1:0]], 16'h0};
          default: m_dout <= 32'hDEAD_BEEF;
        endcase
      end else if (m_addr == 32'h0c && m_we == 4'b1100) csr_sel <= m_din[31:16];
      else if (m_addr == 32'h10 && m_we == 4'b1000) isr_byte <= m_din[31:24];
    end
  end

  // arbiter grant: always, or a random 0-5 cycle stall after each access
  initial begin
    int wait_left;
    wait_left = 0;
    m_gnt = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!rand_gnt) m_gnt = 1'b1;
      else if (acc_seen) begin
        wait_left = $urandom_range(0, 5);
        m_gnt = (wait_left == 0);
      end else if (wait_left > 0) begin
        wait_left--;
        m_gnt = (wait_left == 0);
      end else m_gnt = 1'b1;
    end
  end

  // monitor: bus accesses, stall stability, isr_ack, qinfo records
  initial begin
    logic prev_wait, prev_hold;
    logic [67:0] prev_bus, req;
    logic [79:0] prev_qi, qi;
    prev_wait = 1'b0;
    prev_hold = 1'b0;
    prev_bus = '0;
    prev_qi = '0;
    forever begin
      @(negedge clk);
      req = {m_we, m_addr, (m_we != 4'b0000) ? m_din : 32'h0};
      qi = {qinfo_qidx, qinfo_pfn, qinfo_size, qinfo_msix};
      if (rst) begin
        prev_wait = 1'b0;
        prev_hold = 1'b0;
        acc_seen = 1'b0;
      end else begin
        if (prev_wait) begin
          check_eq("m_en_held", m_en, 1);
          check_eq("m_bus_held", {m_we, m_addr, m_din}, prev_bus);
        end
        if (m_en && m_gnt) begin
          check_eq("acc_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check_eq("acc", req, exp_q.pop_front());
        end
        acc_seen = m_en && m_gnt;
        prev_wait = m_en && !m_gnt;
        prev_bus = {m_we, m_addr, m_din};
        if (isr_ack) begin
          ack_cnt++;
          check_eq("isr_ack_acc", {m_en && m_gnt, m_we, m_addr}, {1'b1, 4'b1000, 32'h10});
        end
        if (prev_hold) begin
          check_eq("qinfo_valid_held", qinfo_valid, 1);
          check_eq("qinfo_held", qi, prev_qi);
        end
        if (qinfo_valid && qinfo_ready) begin
          check_eq("qinfo_expected", qexp_q.size() != 0, 1);
          if (qexp_q.size() != 0) check_eq("qinfo", qi, qexp_q.pop_front());
        end
        prev_hold = qinfo_valid && !qinfo_ready;
        prev_qi = qi;
      end
    end
  end

  // driver tasks
  task automatic push_fetch(input logic [15:0] q);
    exp_q.push_back({4'h0, 32'h10, 32'h0});
    exp_q.push_back({4'h0, 32'h0c, 32'h0});
    exp_q.push_back({4'hc, 32'h0c, q, 16'h0});
    exp_q.push_back({4'h0, 32'h08, 32'h0});
    exp_q.push_back({4'h0, 32'h0c, 32'h0});
    exp_q.push_back({4'h0, 32'h14, 32'h0});
    exp_q.push_back({4'hc, 32'h0c, HOST_SEL, 16'h0});
    qexp_q.push_back({q, q_pfn[q[1:0]], q_size[q[1:0]], q_msix[q[1:0]]});
  endtask

  task automatic do_notify(input logic [15:0] q, input logic with_isr);
    int n;
    @(posedge clk); #1;
    notify_valid = 1'b1;
    notify_qidx = q;
    if (with_isr) begin
      isr_req = 1'b1;
      isr_val = 8'hA5;
    end
    n = 0;
    @(negedge clk);
    while (!notify_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("notify_accepted", notify_ready, 1);
    @(posedge clk); #1;
    notify_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!(exp_q.size() == 0 && qexp_q.size() == 0 && dbg_state == 4'd0) && n < 500);
    check_eq(tag, n < 500, 1);
  endtask

  task automatic check_rst(input string pfx);
    check_eq({pfx, "_m_bus"}, {m_en, m_we, m_addr, m_din}, 0);
    check_eq({pfx, "_handshakes"}, {notify_ready, isr_ack, qinfo_valid}, 0);
    check_eq({pfx, "_qinfo"}, {qinfo_qidx, qinfo_pfn, qinfo_size, qinfo_msix}, 0);
    check_eq({pfx, "_counters"}, {drop_cnt, err_cnt}, 0);
    check_eq({pfx, "_state"}, dbg_state, 0);
  endtask

  // main sequence
  initial begin
    int cnt, ack_base;
    rst = 1'b1;
    notify_valid = 1'b0;
    notify_qidx = '0;
    isr_req = 1'b0;
    isr_val = '0;
    qinfo_ready = 1'b1;
    csr_stat = 32'h0004_0000;
    q_pfn[0] = 32'h0000_A000; q_size[0] = 16'd128; q_msix[0] = 16'd1;
    q_pfn[1] = 32'h0001_2340; q_size[1] = 16'd256; q_msix[1] = 16'd5;
    q_pfn[2] = 32'h000B_EEF0; q_size[2] = 16'd64;  q_msix[2] = 16'hFFFF;
    q_pfn[3] = 32'h0;         q_size[3] = 16'd0;   q_msix[3] = 16'd0;
    repeat (3) @(negedge clk);
    check_rst("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: full fetch of Q1, grant always, latency 9
    push_fetch(16'd1);
    do_notify(16'd1, 1'b0);
    cnt = 1;
    while (cnt < 60) begin
      @(negedge clk);
      if (qinfo_valid) break;
      cnt++;
    end
    check_eq("t1_latency", cnt, 9);
    check_eq("t1_qinfo_fields", {qinfo_qidx, qinfo_pfn, qinfo_size, qinfo_msix},
             {16'd1, 32'h0001_2340, 16'd256, 16'd5});
    wait_idle("t1_done");
    check_eq("t1_sel_restored", csr_sel, HOST_SEL);

    // 2: DRIVER_OK clear -> single status read, drop
    csr_stat = 32'h0;
    exp_q.push_back({4'h0, 32'h10, 32'h0});
    do_notify(16'd0, 1'b0);
    wait_idle("t2_done");
    repeat (3) @(negedge clk);
    check_eq("t2_drop_cnt", drop_cnt, 1);
    check_eq("t2_sel_untouched", csr_sel, HOST_SEL);
    csr_stat = 32'h0004_0000;

    // 3: out-of-range queue index
    do_notify(16'd3, 1'b0);
    @(negedge clk);
    check_eq("t3_ready_back", notify_ready, 1);
    check_eq("t3_no_m_en", m_en, 0);
    check_eq("t3_err_cnt", err_cnt, 1);
    check_eq("t3_drop_cnt", drop_cnt, 1);

    // 4: random grant stalls
    rand_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] q;
      q = (i == 0) ? 16'd1 : (i == 1) ? 16'd2 : 16'd0;
      push_fetch(q);
      do_notify(q, 1'b0);
      wait_idle("t4_done");
      check_eq("t4_sel_restored", csr_sel, HOST_SEL);
    end
    rand_gnt = 1'b0;

    // 5: notify and ISR in the same cycle, notify first
    push_fetch(16'd1);
    exp_q.push_back({4'b1000, 32'h10, 32'hA500_0000});
    ack_base = ack_cnt;
    do_notify(16'd1, 1'b1);
    cnt = 0;
    while (ack_cnt == ack_base && cnt < 200) begin
      @(negedge clk); #2;
      cnt++;
    end
    check_eq("t5_isr_ack_seen", ack_cnt != ack_base, 1);
    @(posedge clk); #1;
    isr_req = 1'b0;
    wait_idle("t5_done");
    repeat (4) @(negedge clk);
    check_eq("t5_isr_ack_once", ack_cnt - ack_base, 1);
    check_eq("t5_isr_byte", isr_byte, 8'hA5);

    // 6: consumer stall, then reset in RD_ADDR
    qinfo_ready = 1'b0;
    push_fetch(16'd2);
    do_notify(16'd2, 1'b0);
    cnt = 0;
    while (!qinfo_valid && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    repeat (10) @(negedge clk);
    check_eq("t6_valid_held", qinfo_valid, 1);
    @(posedge clk); #1;
    qinfo_ready = 1'b1;
    wait_idle("t6_drain");
    push_fetch(16'd0);
    do_notify(16'd0, 1'b0);
    cnt = 0;
    while (dbg_state != 4'd5 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("t6_reached_rd_addr", dbg_state, 5);
    #1 rst = 1'b1;
    #1 check_rst("t6_reset");
    exp_q.delete();
    qexp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_fetch(16'd1);
    do_notify(16'd1, 1'b0);
    wait_idle("t6_after_reset");
    check_eq("t6_sel_restored", csr_sel, HOST_SEL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
